ahb_lite_mem_slave: RTL
=======================

// Module: ahb_lite_mem_slave
// PURPOSE
//  AHB-Lite responder with a word-organised memory, programmable wait states and an ERROR response.
//  Sits on the slave side of the AHB VIP interface. Serves as the default DUT-side target for
//  master-driver bring-up and as a reference slave in subsystem benches.
// PARAMETERS
//  ADDR_WIDTH   32    byte-address width of haddr
//  DATA_WIDTH   32    hwdata/hrdata width; 32 or 64 only
//  MEM_DEPTH    256   memory size in DATA_WIDTH words; legal byte range 0..MEM_DEPTH*DATA_WIDTH/8-1
//  WAIT_STATES  0     hready-low cycles inserted in every OKAY data phase; 0..15
// PORTS
//  hclk     in   1           bus clock, all state on rising edge
//  hresetn  in   1           asynchronous active-low reset
//  hsel     in   1           slave select
//  haddr    in   ADDR_WIDTH  byte address (address phase)
//  htrans   in   2           IDLE/BUSY/NONSEQ/SEQ
//  hwrite   in   1           1 = write, 0 = read
//  hsize    in   3           transfer size
//  hburst   in   3           burst type; ignored, every beat decoded independently
//  hprot    in   4           ignored
//  hwdata   in   DATA_WIDTH  write data (data phase)
//  hrdata   out  DATA_WIDTH  read data
//  hready   out  1           transfer done; also used internally as the address-phase qualifier
//  hresp    out  1           0 = OKAY, 1 = ERROR
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): hready=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0.
//    Memory contents are not reset.
//  - Accept: address phase taken on a rising edge with hsel & hready & htrans[1].
//    haddr, hwrite and hsize are registered at that edge. IDLE/BUSY, or hsel=0: no transfer,
//    next cycle hready=1, hresp=0. Any address phase while hready=0 is ignored.
//  - Error check at accept: ERROR if any of:
//    - haddr >= MEM_DEPTH*DATA_WIDTH/8;
//    - hsize > log2(DATA_WIDTH/8);
//    - haddr is not aligned to hsize.
//  - FSM states IDLE, WAIT, DATA, ERR1, ERR2:
//    - IDLE->DATA when an OKAY transfer is accepted and WAIT_STATES=0.
//    - IDLE->WAIT when WAIT_STATES>0; the counter loads WAIT_STATES-1.
//    - WAIT: hready=0, hresp=0; the counter decrements; at 0 go to DATA.
//    - DATA: hready=1, hresp=0. If a new transfer is accepted this cycle, the next state
//      is DATA, WAIT or ERR1 per the rules above; otherwise IDLE.
//    - ERR1: hready=0, hresp=1, always ->ERR2.
//    - ERR2: hready=1, hresp=1. The accept rules apply, identical to DATA.
//    - The ERROR response ignores WAIT_STATES.
//  - Latency: an OKAY transfer completes WAIT_STATES+1 cycles after accept.
//    With WAIT_STATES=0, back-to-back NONSEQ/SEQ beats get zero-wait pipelining.
//  - Write: in DATA, hwdata byte lanes selected by the registered addr[log2(DW/8)-1:0] and hsize
//    are written at the closing edge. A write is never performed for an ERROR transfer.
//  - Read: in DATA, hrdata = full memory word at the registered address; all lanes are driven.
//    In every other cycle hrdata = 0. A read immediately following a write to the same word
//    returns the new data, because the write commits at the edge ending its data phase.
//  - Reset mid-transfer (WAIT/ERR1/DATA): the FSM returns to IDLE and any pending write is dropped.
//  - Simultaneous data-phase completion and new address phase are legal and must not lose either.
// STRUCTURE
//  - ahb_pkg, shared with the VIP, holds htrans_t, hsize_t, hburst_t and hresp_t. The FSM state
//    enum stays local.
//  - One sub-module, ahb_lite_mem_bytes: MEM_DEPTH x DATA_WIDTH array.
//    - Per-byte write enable; combinational read by word index.
//  - The top holds the address/control register, FSM, wait counter, error decode and lane-enable
//    generation.
// TESTING
//  1. WAIT_STATES=0. Write NONSEQ WORD 0x10 = 0xDEADBEEF, then read 0x10.
//     -> hready stays 1 throughout; hrdata = 0xDEADBEEF in the 2nd data phase; hresp=0.
//  2. Byte writes 0x20=0x11, 0x21=0x22, 0x23=0x44, then WORD read 0x20.
//     -> 0x4400_2211 when 0x22 was zero-initialised by a prior WORD write of 0.
//  3. WAIT_STATES=2. Read 0x04.
//     -> 2 cycles hready=0, hresp=0, then hready=1 with data.
//     -> The next address phase presented during the waits is held and taken only on the hready=1 edge.
//  4. Read from 0x400 (MEM_DEPTH=256):
//     -> ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1).
//     -> Write of 0x55 to 0x400 leaves memory unchanged.
//     -> HALFWORD at 0x01 also gives ERROR.
//  5. htrans=BUSY and IDLE with hsel=1, and NONSEQ with hsel=0.
//     -> hready=1, hresp=0, no memory change.
//  6. Assert hresetn during WAIT of a write to 0x08 (WAIT_STATES=3).
//     -> outputs go to reset values asynchronously; a later read of 0x08 returns its prior value.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite bus encodings shared between the VIP and the slave-side responders.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    function automatic logic trans_active(input htrans_t t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_mem_bytes.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module ahb_lite_mem_bytes #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         clk,
    input  logic [DATA_WIDTH/8-1:0]      byte_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] idx,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (byte_en[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory responder: registered address phase, programmable wait states,
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_lite_mem_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp
);

    localparam int unsigned    NBYTES    = DATA_WIDTH / 8;
    localparam int             LANE_W    = $clog2(DATA_WIDTH / 8);
    localparam int             IDX_W     = $clog2(MEM_DEPTH);
    localparam longint unsigned MEM_BYTES = 64'(MEM_DEPTH) * 64'(NBYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t              state;
    logic                hready_r;
    hresp_t              resp_r;
    logic [3:0]          wait_cnt;
    logic                write_r;
    hsize_t              size_r;
    logic [LANE_W-1:0]   lane_r;
    logic [IDX_W-1:0]    idx_r;

    htrans_t             trans;
    hburst_t             burst;
    logic                accept;
    logic                addr_err;
    logic                size_err;
    logic                align_err;
    logic                req_err;
    logic [LANE_W-1:0]   align_mask;
    logic [NBYTES-1:0]   byte_en;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                unused_ok;

    assign trans  = htrans_t'(htrans);
    assign burst  = hburst_t'(hburst);
    assign accept = hsel && hready_r && trans_active(trans);

    assign addr_err   = (64'(haddr) >= MEM_BYTES);
    assign size_err   = (hsize > 3'(LANE_W));
    assign align_mask = LANE_W'((32'd1 << hsize) - 32'd1);
    assign align_err  = |(haddr[LANE_W-1:0] & align_mask);
    assign req_err    = addr_err || size_err || align_err;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= S_IDLE;
            hready_r <= 1'b1;
            resp_r   <= HRESP_OKAY;
            wait_cnt <= '0;
            write_r  <= 1'b0;
            size_r   <= HSIZE_BYTE;
            lane_r   <= '0;
            idx_r    <= '0;
        end else begin
            unique case (state)
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= S_DATA;
                        hready_r <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state    <= S_ERR2;
                    hready_r <= 1'b1;
                    resp_r   <= HRESP_ERROR;
                end
                // IDLE, DATA and ERR2 all drive hready=1, so each can take a new address phase
                default: begin
                    if (accept) begin
                        write_r <= hwrite;
                        size_r  <= hsize_t'(hsize);
                        lane_r  <= haddr[LANE_W-1:0];
                        idx_r   <= haddr[LANE_W +: IDX_W];
                        if (req_err) begin
                            state    <= S_ERR1;
                            hready_r <= 1'b0;
                            resp_r   <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state    <= S_DATA;
                            hready_r <= 1'b1;
                            resp_r   <= HRESP_OKAY;
                        end else begin
                            state    <= S_WAIT;
                            hready_r <= 1'b0;
                            resp_r   <= HRESP_OKAY;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end
                    end else begin
                        state    <= S_IDLE;
                        hready_r <= 1'b1;
                        resp_r   <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    always_comb begin
        int unsigned lo;
        int unsigned hi;
        byte_en = '0;
        lo      = 32'(lane_r);
        hi      = lo + (32'd1 << size_r);
        if (state == S_DATA && write_r) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                byte_en[i] = (i >= lo) && (i < hi);
            end
        end
    end

    ahb_lite_mem_bytes #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk     (hclk),
        .byte_en (byte_en),
        .idx     (idx_r),
        .wdata   (hwdata),
        .rdata   (mem_rdata)
    );

    assign hrdata = (state == S_DATA && !write_r) ? mem_rdata : '0;
    assign hready = hready_r;
    assign hresp  = resp_r;

    assign unused_ok = ^{burst, hprot};

endmodule
